// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mc_pkg                                                          |
// | Brief    : Opcodes, state encodings, select codes and instruction classes  |
// |            shared by the MIPS-lite multi-cycle controller.                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [1:0] EOP_SIGN     = 2'b00;
  localparam logic [1:0] EOP_ZERO     = 2'b01;
  localparam logic [1:0] EOP_LUI      = 2'b10;
  localparam logic [1:0] EOP_SIGN_SL2 = 2'b11;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_REG  = 2'b11;

  localparam logic [1:0] WA_RD = 2'b00;
  localparam logic [1:0] WA_RT = 2'b01;
  localparam logic [1:0] WA_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } instr_class_t;

  function automatic logic [1:0] eop_of(instr_class_t c);
    logic [1:0] r;
    r = EOP_SIGN;
    if (c.ori)      r = EOP_ZERO;
    else if (c.lui) r = EOP_LUI;
    else if (c.beq) r = EOP_SIGN_SL2;
    return r;
  endfunction

  function automatic logic [2:0] alu_op_of(instr_class_t c);
    logic [2:0] r;
    r = ALU_ADD;
    if (c.subu || c.beq) r = ALU_SUB;
    else if (c.ori)      r = ALU_OR;
    return r;
  endfunction

  function automatic logic alu_src_of(instr_class_t c);
    return c.ori | c.lui | c.lw | c.sw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mc_if                                                           |
// | Brief    : Controller <-> datapath bundle: IR/flags in, selects/strobes out|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mc_if #(
  parameter int STATE_W = 3,
  parameter int ALUOP_W = 3
);
  logic [31:0]        instr;
  logic               zero;
  logic               mem_ready;
  logic               pc_we;
  logic               ir_we;
  logic [1:0]         npc_sel;
  logic [1:0]         eop;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               reg_we;
  logic [1:0]         wa_sel;
  logic [1:0]         wd_sel;
  logic               mem_we;
  logic [STATE_W-1:0] state_o;
  logic               illegal;

  modport master (
    input  instr, zero, mem_ready,
    output pc_we, ir_we, npc_sel, eop, alu_src, alu_op,
           reg_we, wa_sel, wd_sel, mem_we, state_o, illegal
  );

  modport slave (
    output instr, zero, mem_ready,
    input  pc_we, ir_we, npc_sel, eop, alu_src, alu_op,
           reg_we, wa_sel, wd_sel, mem_we, state_o, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mc_decode                                                       |
// | Brief    : Combinational instruction classifier (one-hot class vector).    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0]  instr_i,
  output instr_class_t cls_o
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_rtype;
  logic       w_unused_fields;

  assign w_op            = instr_i[31:26];
  assign w_fn            = instr_i[5:0];
  assign w_rtype         = (w_op == OP_RTYPE);
  assign w_unused_fields = ^instr_i[25:6];

  always_comb begin
    cls_o      = '0;
    cls_o.addu = w_rtype && (w_fn == FN_ADDU);
    cls_o.subu = w_rtype && (w_fn == FN_SUBU);
    cls_o.jr   = w_rtype && (w_fn == FN_JR);
    cls_o.ori  = (w_op == OP_ORI);
    cls_o.lw   = (w_op == OP_LW);
    cls_o.sw   = (w_op == OP_SW);
    cls_o.beq  = (w_op == OP_BEQ);
    cls_o.lui  = (w_op == OP_LUI);
    cls_o.j    = (w_op == OP_J);
    cls_o.jal  = (w_op == OP_JAL);
    cls_o.illegal = ~(cls_o.addu | cls_o.subu | cls_o.jr | cls_o.ori | cls_o.lw |
                      cls_o.sw | cls_o.beq | cls_o.lui | cls_o.j | cls_o.jal);
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mc_ctrl                                                         |
// | Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for MIPS-lite.  |
// |            Define MC_MEM_WAIT_EN to stall MEM on the mem_ready handshake.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 3,
  parameter int ALUOP_W = 3
) (
  input  logic  clk,
  input  logic  reset,
  mc_if.master  bus
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  instr_class_t       w_cls;
  logic               w_mem_done;

  mc_decode u_decode (
    .instr_i (bus.instr),
    .cls_o   (w_cls)
  );

`ifdef MC_MEM_WAIT_EN
  assign w_mem_done = bus.mem_ready;
`else
  assign w_mem_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (w_cls.j || w_cls.illegal) state_d = ST_FETCH;
        else if (w_cls.jal)           state_d = ST_WB;
        else                          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_cls.lw || w_cls.sw)                                 state_d = ST_MEM;
        else if (w_cls.addu || w_cls.subu || w_cls.ori || w_cls.lui) state_d = ST_WB;
        else                                                      state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (!w_mem_done) state_d = ST_MEM;
        else if (w_cls.lw) state_d = ST_WB;
        else               state_d = ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are gated by reset directly so nothing is enabled while it is held.
  always_comb begin
    bus.pc_we   = 1'b0;
    bus.ir_we   = 1'b0;
    bus.npc_sel = NPC_PC4;
    bus.eop     = EOP_SIGN;
    bus.alu_src = 1'b0;
    bus.alu_op  = '0;
    bus.reg_we  = 1'b0;
    bus.wa_sel  = WA_RD;
    bus.wd_sel  = WD_ALU;
    bus.mem_we  = 1'b0;
    bus.illegal = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          bus.ir_we   = 1'b1;
          bus.pc_we   = 1'b1;
          bus.npc_sel = NPC_PC4;
        end
        ST_DECODE: begin
          if (w_cls.j) begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_JUMP;
          end else if (w_cls.illegal) begin
            bus.illegal = 1'b1;
          end
        end
        ST_EXEC: begin
          bus.eop     = eop_of(w_cls);
          bus.alu_src = alu_src_of(w_cls);
          bus.alu_op  = ALUOP_W'(alu_op_of(w_cls));
          if (w_cls.beq) begin
            bus.pc_we   = bus.zero;
            bus.npc_sel = NPC_BR;
          end else if (w_cls.jr) begin
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_REG;
          end
        end
        ST_MEM: begin
          // Address operands stay selected so the DM address is stable across waits.
          bus.eop     = eop_of(w_cls);
          bus.alu_src = alu_src_of(w_cls);
          bus.alu_op  = ALUOP_W'(alu_op_of(w_cls));
          bus.mem_we  = w_cls.sw;
        end
        ST_WB: begin
          bus.reg_we = 1'b1;
          if (w_cls.addu || w_cls.subu) begin
            bus.wa_sel = WA_RD;
            bus.wd_sel = WD_ALU;
          end else if (w_cls.lw) begin
            bus.wa_sel = WA_RT;
            bus.wd_sel = WD_DM;
          end else if (w_cls.jal) begin
            bus.wa_sel  = WA_RA;
            bus.wd_sel  = WD_PC;
            bus.pc_we   = 1'b1;
            bus.npc_sel = NPC_JUMP;
          end else begin
            bus.wa_sel = WA_RT;
            bus.wd_sel = WD_ALU;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mc_ctrl                                                      |
// | Brief    : Directed + random self-checking bench for mc_ctrl.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mc_ctrl;
  import mc_pkg::ST_FETCH, mc_pkg::ST_DECODE, mc_pkg::ST_EXEC, mc_pkg::ST_MEM, mc_pkg::ST_WB;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_if bus ();
  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_JAL, K_JR, K_ILL} kind_e;
  typedef struct packed { logic [2:0] st; logic [16:0] o; } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // {pc_we, ir_we, npc_sel, eop, alu_src, alu_op, reg_we, wa_sel, wd_sel, mem_we, illegal}
  function automatic logic [16:0] pk(logic pc, logic ir, logic [1:0] npc, logic [1:0] eop,
                                     logic src, logic [2:0] aop, logic rwe, logic [1:0] wa,
                                     logic [1:0] wd, logic mwe, logic ill);
    return {pc, ir, npc, eop, src, aop, rwe, wa, wd, mwe, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.pc_we, bus.ir_we, bus.npc_sel, bus.eop, bus.alu_src, bus.alu_op,
            bus.reg_we, bus.wa_sel, bus.wd_sel, bus.mem_we, bus.illegal};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Expected per-cycle behaviour of one instruction, straight from the phase table.
  task automatic build(kind_e k, logic z, int w);
    logic [1:0] eop; logic src; logic [2:0] aop; int n;
    exp_q.delete();
    eop = 2'b00; src = 1'b0; aop = 3'b000;
    case (k)
      K_ORI:       begin eop = 2'b01; src = 1'b1; aop = 3'b010; end
      K_LUI:       begin eop = 2'b10; src = 1'b1; end
      K_LW, K_SW:  src = 1'b1;
      K_BEQ:       begin eop = 2'b11; aop = 3'b001; end
      K_SUBU:      aop = 3'b001;
      default: ;
    endcase
    exp_q.push_back('{ST_FETCH, pk(1,1,2'b00,2'b00,0,3'b000,0,2'b00,2'b00,0,0)});
    if (k == K_J)        exp_q.push_back('{ST_DECODE, pk(1,0,2'b10,2'b00,0,3'b000,0,2'b00,2'b00,0,0)});
    else if (k == K_ILL) exp_q.push_back('{ST_DECODE, pk(0,0,2'b00,2'b00,0,3'b000,0,2'b00,2'b00,0,1)});
    else                 exp_q.push_back('{ST_DECODE, 17'h0});
    if (k == K_J || k == K_ILL) return;
    if (k == K_JAL) begin
      exp_q.push_back('{ST_WB, pk(1,0,2'b10,2'b00,0,3'b000,1,2'b10,2'b10,0,0)});
      return;
    end
    if (k == K_BEQ)     exp_q.push_back('{ST_EXEC, pk(z,0,2'b01,eop,src,aop,0,2'b00,2'b00,0,0)});
    else if (k == K_JR) exp_q.push_back('{ST_EXEC, pk(1,0,2'b11,eop,src,aop,0,2'b00,2'b00,0,0)});
    else                exp_q.push_back('{ST_EXEC, pk(0,0,2'b00,eop,src,aop,0,2'b00,2'b00,0,0)});
    if (k == K_BEQ || k == K_JR) return;
    if (k == K_LW || k == K_SW) begin
      n = WAIT_EN ? 1 + w : 1;
      for (int i = 0; i < n; i++)
        exp_q.push_back('{ST_MEM, pk(0,0,2'b00,eop,src,aop,0,2'b00,2'b00,(k == K_SW),0)});
      if (k == K_SW) return;
    end
    exp_q.push_back('{ST_WB, pk(0,0,2'b00,2'b00,0,3'b000,1,
                                (k == K_ADDU || k == K_SUBU) ? 2'b00 : 2'b01,
                                (k == K_LW) ? 2'b01 : 2'b00, 0, 0)});
  endtask

  function automatic logic [31:0] enc(kind_e k);
    logic [4:0] rs, rt, rd; logic [15:0] imm; logic [25:0] idx; logic [31:0] r;
    logic [5:0] bad_op [5]; logic [5:0] bad_fn [4];
    bad_op = '{6'h3f, 6'h08, 6'h0a, 6'h20, 6'h05};
    bad_fn = '{6'h20, 6'h22, 6'h24, 6'h00};
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = 16'($urandom); idx = 26'($urandom);
    case (k)
      K_ADDU: r = {6'h00, rs, rt, rd, 5'h0, 6'h21};
      K_SUBU: r = {6'h00, rs, rt, rd, 5'h0, 6'h23};
      K_JR:   r = {6'h00, rs, 15'h0, 6'h08};
      K_ORI:  r = {6'h0d, rs, rt, imm};
      K_LW:   r = {6'h23, rs, rt, imm};
      K_SW:   r = {6'h2b, rs, rt, imm};
      K_BEQ:  r = {6'h04, rs, rt, imm};
      K_LUI:  r = {6'h0f, 5'h0, rt, imm};
      K_J:    r = {6'h02, idx};
      K_JAL:  r = {6'h03, idx};
      default: begin
        if ($urandom_range(0, 1) == 0) r = {bad_op[$urandom_range(0, 4)], idx};
        else r = {6'h00, rs, rt, rd, 5'h0, bad_fn[$urandom_range(0, 3)]};
      end
    endcase
    return r;
  endfunction

  // Entered just after a rising edge with the DUT in FETCH; abort_at stops after checking that cycle.
  task automatic run(string name, logic [31:0] ins, kind_e k, logic z, int w, int abort_at);
    build(k, z, w);
    bus.instr = ins;
    bus.zero  = z;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = WAIT_EN ? (i >= 3 + w) : 1'($urandom);
      @(negedge clk);
      chk($sformatf("%s c%0d state", name, i), 32'(bus.state_o), 32'(exp_q[i].st));
      chk($sformatf("%s c%0d outs", name, i), 32'(observed()), 32'(exp_q[i].o));
      if (i == abort_at) return;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.instr = 32'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset c%0d state", i), 32'(bus.state_o), 32'(ST_FETCH));
      chk($sformatf("reset c%0d outs", i), 32'(observed()), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run("addu",   32'h00221821, K_ADDU, 1'b0, 0, -1);
    run("lui",    32'h3c041234, K_LUI,  1'b0, 0, -1);
    run("beq_z1", 32'h10220004, K_BEQ,  1'b1, 0, -1);
    run("beq_z0", 32'h10220004, K_BEQ,  1'b0, 0, -1);
    run("lw_w2",  32'h8c250010, K_LW,   1'b0, 2, -1);
    run("jal",    32'h0c000100, K_JAL,  1'b0, 0, -1);
    run("ill3f",  32'hfc000000, K_ILL,  1'b0, 0, -1);
    run("jr",     32'h03e00008, K_JR,   1'b0, 0, -1);

    // Reset dropped in while sw is in MEM: mem_we must fall immediately.
    run("sw_rst", 32'hac250008, K_SW, 1'b0, 0, 3);
    #1 reset = 1'b1;
    #1;
    chk("sw_rst async state", 32'(bus.state_o), 32'(ST_FETCH));
    chk("sw_rst async outs", 32'(observed()), 32'h0);
    @(posedge clk); #1;
    chk("sw_rst held state", 32'(bus.state_o), 32'(ST_FETCH));
    chk("sw_rst held mem_we", 32'(bus.mem_we), 32'h0);
    reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      kind_e k;
      k = kind_e'($urandom_range(0, 10));
      run($sformatf("rnd%0d_%s", n, k.name()), enc(k), k, 1'($urandom), $urandom_range(0, 3), -1);
    end

    @(negedge clk);
    chk("final state", 32'(bus.state_o), 32'(ST_FETCH));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
